// File: rtl/wrr_arb.sv
// -----------------------------------------------------------------------------
// wrr_arb -- weighted round-robin arbiter with grant lock.
//
// Shares one internal bus among REQ_NUM requesters. Each requester owns a
// credit counter that is loaded from its weight whenever every requesting
// channel has run out of credit. A grant is registered, one-hot, and held
// until the owner pulses gnt_done. There is one dead cycle between grants.
//
// Ports:
//   clk       in   1                 clock
//   rst       in   1                 asynchronous reset, active-high
//   req       in   REQ_NUM           level request vector
//   wgt       in   REQ_NUM*WGT_WID   weights, channel i at wgt[i*WGT_WID +: WGT_WID]
//   gnt_done  in   1                 one-cycle pulse: granted transfer finished
//   gnt_vld   out  1                 grant valid (registered)
//   gnt       out  REQ_NUM           one-hot grant, 0 when !gnt_vld
//   gnt_id    out  ID_WID            granted index, 0 when !gnt_vld
//   dbg_sig   out  DBG_WID           [0]=state, [ID_WID:1]=ptr, rest 0
// -----------------------------------------------------------------------------
module wrr_arb #(
    parameter int REQ_NUM = 4,
    parameter int ID_WID  = $clog2(REQ_NUM),
    parameter int WGT_WID = 4,
    parameter int DBG_WID = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_NUM-1:0]         req,
    input  logic [REQ_NUM*WGT_WID-1:0] wgt,
    input  logic                       gnt_done,
    output logic                       gnt_vld,
    output logic [REQ_NUM-1:0]         gnt,
    output logic [ID_WID-1:0]          gnt_id,
    output logic [DBG_WID-1:0]         dbg_sig
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_WID-1:0]   ptr;
    logic [WGT_WID-1:0]  credit  [REQ_NUM];
    logic [WGT_WID-1:0]  wgt_eff [REQ_NUM];
    logic [REQ_NUM-1:0]  has_credit;
    logic [REQ_NUM-1:0]  elig;
    logic [REQ_NUM-1:0]  cand;
    logic                reload;
    logic [ID_WID-1:0]   win;
    logic [WGT_WID-1:0]  cur_credit;
    logic [WGT_WID-1:0]  dec_credit;
    logic [ID_WID-1:0]   ptr_after;

    // First set bit of c, searching p, p+1, ... with explicit wrap so that
    // REQ_NUM need not be a power of two.
    function automatic logic [ID_WID-1:0] pick_first(
        input logic [REQ_NUM-1:0] c,
        input logic [ID_WID-1:0]  p
    );
        logic              found;
        int                idx;
        logic [ID_WID-1:0] idx_w;
        pick_first = '0;
        found      = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = int'(p) + i;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            idx_w = ID_WID'(idx);
            if (!found && c[idx_w]) begin
                pick_first = idx_w;
                found      = 1'b1;
            end
        end
    endfunction

    // Arbitration: when no requester has credit left, a reload is due and
    // the raw request vector decides this round's winner.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            has_credit[i] = (credit[i] != '0);
            wgt_eff[i]    = (wgt[i*WGT_WID +: WGT_WID] == '0) ? WGT_WID'(1)
                                                              : wgt[i*WGT_WID +: WGT_WID];
        end
        elig   = req & has_credit;
        reload = (elig == '0) && (req != '0);
        cand   = reload ? req : elig;
        win    = pick_first(cand, ptr);
    end

    // Credit consumption at end of transfer; the owner keeps priority until
    // its credit is exhausted, then priority moves to the next channel.
    always_comb begin
        cur_credit = credit[gnt_id];
        dec_credit = (cur_credit == '0) ? '0 : cur_credit - WGT_WID'(1);
        if (gnt_id == ID_WID'(REQ_NUM - 1)) begin
            ptr_after = '0;
        end else begin
            ptr_after = gnt_id + ID_WID'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != '0) state_next = GRANT;
            GRANT:   if (gnt_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_vld <= 1'b0;
            gnt     <= '0;
            gnt_id  <= '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                credit[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        if (reload) begin
                            for (int i = 0; i < REQ_NUM; i++) begin
                                credit[i] <= wgt_eff[i];
                            end
                        end
                        gnt_vld <= 1'b1;
                        gnt     <= {{(REQ_NUM-1){1'b0}}, 1'b1} << win;
                        gnt_id  <= win;
                    end
                end
                GRANT: begin
                    if (gnt_done) begin
                        credit[gnt_id] <= dec_credit;
                        ptr            <= (dec_credit == '0) ? ptr_after : gnt_id;
                        gnt_vld        <= 1'b0;
                        gnt            <= '0;
                        gnt_id         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_sig = {{(DBG_WID-ID_WID-1){1'b0}}, ptr, (state == GRANT)};

endmodule

// File: tb/tb_wrr_arb.sv
module tb_wrr_arb;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*WW-1:0] wgt;
    logic          gnt_done;
    logic          gnt_vld;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic [31:0]   dbg_sig;

    wrr_arb #(.REQ_NUM(N), .WGT_WID(WW), .DBG_WID(32)) dut (
        .clk(clk), .rst(rst), .req(req), .wgt(wgt), .gnt_done(gnt_done),
        .gnt_vld(gnt_vld), .gnt(gnt), .gnt_id(gnt_id), .dbg_sig(dbg_sig)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-channel credits, priority pointer, owner.
    int m_cred [N];
    int m_ptr;
    bit m_busy;
    int m_owner;
    bit auto_done;
    bit prev_vld;
    int dut_order[$];
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cred[i] = 0;
        m_ptr = 0; m_busy = 0; m_owner = 0; prev_vld = 0;
    endfunction

    // One clock edge of the arbiter, described by its rules.
    function automatic void model_edge();
        int w;
        int c;
        bit any;
        if (!m_busy) begin
            if (req != 0) begin
                any = 0;
                for (int i = 0; i < N; i++) if (req[i] && m_cred[i] > 0) any = 1;
                if (!any) begin
                    for (int i = 0; i < N; i++) begin
                        c = int'(wgt[i*WW +: WW]);
                        m_cred[i] = (c == 0) ? 1 : c;
                    end
                end
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (w < 0 && req[idx] && (!any || m_cred[idx] > 0)) w = idx;
                end
                m_busy  = 1;
                m_owner = w;
            end
        end else if (gnt_done) begin
            if (m_cred[m_owner] > 0) m_cred[m_owner] = m_cred[m_owner] - 1;
            m_ptr  = (m_cred[m_owner] == 0) ? (m_owner + 1) % N : m_owner;
            m_busy = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt_vld", 32'(gnt_vld), 32'(m_busy));
        check("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
        check("gnt_id", 32'(gnt_id), m_busy ? 32'(m_owner) : 32'd0);
        check("dbg_sig", dbg_sig, 32'((m_ptr << 1) | int'(m_busy)));
        if (gnt_vld && !prev_vld) dut_order.push_back(int'(gnt_id));
        prev_vld = gnt_vld;
        if (auto_done) gnt_done = m_busy;
    endtask

    // Async reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        gnt_done = 1'b0;
        #1;
        check("rst_vld", 32'(gnt_vld), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_id", 32'(gnt_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_dbg", dbg_sig, 32'd0);
        dut_order.delete();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_order(input string tag);
        check({tag, "_count_ok"}, 32'(dut_order.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < dut_order.size())
                check($sformatf("%s_g%0d", tag, i), 32'(dut_order[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; wgt = '0; gnt_done = 1'b0; auto_done = 1'b0;
        model_reset();
        #1;
        check("init_vld", 32'(gnt_vld), 32'd0);
        check("init_gnt", 32'(gnt), 32'd0);
        check("init_id", 32'(gnt_id), 32'd0);
        check("init_dbg", dbg_sig, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Equal weights: plain round robin.
        req = 4'b1111; wgt = 16'h1111; auto_done = 1'b1;
        run_cycles(13);
        exp_q = '{0, 1, 2, 3, 0, 1};
        check_order("rr");

        // ch0 weight 3.
        async_reset();
        req = 4'b1111; wgt = 16'h1113;
        run_cycles(19);
        exp_q = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        check_order("w3");

        // Single requester, weight 2.
        async_reset();
        req = 4'b0100; wgt = 16'h0200;
        run_cycles(11);
        exp_q = '{2, 2, 2, 2, 2};
        check_order("solo");

        // gnt_done in IDLE ignored; req changes during GRANT ignored.
        async_reset();
        auto_done = 1'b0;
        req = 4'b0000; wgt = 16'h1111; gnt_done = 1'b1;
        run_cycles(2);
        gnt_done = 1'b0; req = 4'b0010;
        step();
        req = 4'b1000;
        run_cycles(3);
        check("hold_gnt", 32'(gnt), 32'h2);
        gnt_done = 1'b1;
        step();
        gnt_done = 1'b0;
        step();
        check("after_hold_id", 32'(gnt_id), 32'd3);
        check("after_hold_vld", 32'(gnt_vld), 32'd1);

        // Reset mid-GRANT of ch2's second grant discards credit and ptr.
        async_reset();
        auto_done = 1'b1;
        req = 4'b0100; wgt = 16'h3333;
        run_cycles(3);
        check("pre_rst_vld", 32'(gnt_vld), 32'd1);
        check("pre_rst_id", 32'(gnt_id), 32'd2);
        async_reset();
        req = 4'b0101;
        run_cycles(15);
        exp_q = '{0, 0, 0, 2, 2, 2, 0};
        check_order("post_rst");

        // Randomized traffic against the model.
        async_reset();
        auto_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 19) == 0) wgt = 16'($urandom);
            gnt_done = ($urandom_range(0, 2) == 0);
            if (i == 300) async_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
